// File: rtl/ecg_pkg.sv
// Shared constants for the ECG waveform DAC sequencer: FSM state encoding,
// DAC frame geometry and the helper that assembles a frame word.
package ecg_pkg;

  localparam int DAC_FRAME_W = 16;
  localparam int DAC_CFG_W   = 4;
  localparam int SAMPLE_W    = 12;

  localparam logic [DAC_CFG_W-1:0] DAC_CFG_DEFAULT = 4'b0011;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE  = 3'd0;
  localparam fsm_state_t ST_FETCH = 3'd1;
  localparam fsm_state_t ST_LOAD  = 3'd2;
  localparam fsm_state_t ST_SHIFT = 3'd3;
  localparam fsm_state_t ST_GAP   = 3'd4;

  function automatic logic [DAC_FRAME_W-1:0] dac_frame(
    input logic [DAC_CFG_W-1:0] cfg,
    input logic [SAMPLE_W-1:0]  smp
  );
    return {cfg, smp};
  endfunction

endpackage

// File: rtl/dac_spi_tx.sv
// 16-bit MSB-first serialiser: one setup clk after load, then per bit SCLK high
// for SCLK_HALF clk and low for SCLK_HALF clk; data moves only on falling SCLK.
module dac_spi_tx
  import ecg_pkg::*;
#(
  parameter int SCLK_HALF = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DAC_FRAME_W-1:0] word,
  output logic                   sclk,
  output logic                   din,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [DAC_FRAME_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic                   sclk_q, sclk_d;
  logic                   active_q, active_d;
  logic                   pre_q, pre_d;
  logic                   phase_end;
  logic                   last_bit;

  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    active_d  = active_q;
    pre_d     = pre_q;
    phase_end = (cnt_q == CNT_W'(SCLK_HALF - 1));
    last_bit  = (bit_q == 4'(DAC_FRAME_W - 1));
    done      = active_q && !pre_q && !sclk_q && phase_end && last_bit;

    if (load) begin
      shreg_d  = word;
      cnt_d    = '0;
      bit_d    = '0;
      sclk_d   = 1'b0;
      active_d = 1'b1;
      pre_d    = 1'b1;
    end else if (pre_q) begin
      // MSB has been on din for a full clk; start the first high phase
      pre_d  = 1'b0;
      sclk_d = 1'b1;
    end else if (active_q) begin
      cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
      if (phase_end) begin
        if (sclk_q) begin
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[DAC_FRAME_W-2:0], 1'b0};
        end else if (last_bit) begin
          active_d = 1'b0;
        end else begin
          sclk_d = 1'b1;
          bit_d  = bit_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
      pre_q    <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      active_q <= active_d;
      pre_q    <= pre_d;
    end
  end

  assign sclk = sclk_q;
  assign din  = shreg_q[DAC_FRAME_W-1];
  assign busy = active_q;

endmodule

// File: rtl/ecg_dac_seq.sv
// ECG waveform player: divides clk into sample ticks, fetches a table sample
// per tick and ships it to a serial DAC as a {config, sample} frame.
module ecg_dac_seq
  import ecg_pkg::*;
#(
  parameter int             SAMPLE_DIV = 100000,
  parameter int             N_SAMPLES  = 500,
  parameter int             SCLK_HALF  = 2,
  parameter logic [3:0]     DAC_CFG    = DAC_CFG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [8:0]  addr,
  input  logic [11:0] sample,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  overrun_cnt
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int GAP_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  fsm_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [8:0]       addr_q, addr_d;
  logic [7:0]       ovr_q, ovr_d;
  logic             cs_n_q, cs_n_d;
  logic             frame_done_q, frame_done_d;
  logic             tick;
  logic             tx_load, tx_busy, tx_done;

  always_comb begin
    tick         = en && (div_q == DIV_W'(SAMPLE_DIV - 1));
    div_d        = (!en || tick) ? '0 : div_q + DIV_W'(1);
    state_d      = state_q;
    gap_d        = gap_q;
    addr_d       = addr_q;
    ovr_d        = ovr_q;
    cs_n_d       = cs_n_q;
    frame_done_d = 1'b0;
    // Sample is already valid in FETCH because addr settled at least two clk earlier
    tx_load      = (state_q == ST_FETCH);

    if (tick && (state_q != ST_IDLE) && (ovr_q != 8'hFF))
      ovr_d = ovr_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
        cs_n_d  = 1'b0;
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tx_done || !tx_busy) begin
          state_d = ST_GAP;
          cs_n_d  = 1'b1;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(SCLK_HALF - 1)) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          addr_d       = (addr_q == 9'(N_SAMPLES - 1)) ? 9'd0 : addr_q + 9'd1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      gap_q        <= '0;
      addr_q       <= '0;
      ovr_q        <= '0;
      cs_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      gap_q        <= gap_d;
      addr_q       <= addr_d;
      ovr_q        <= ovr_d;
      cs_n_q       <= cs_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  dac_spi_tx #(
    .SCLK_HALF(SCLK_HALF)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .word (dac_frame(DAC_CFG, sample)),
    .sclk (dac_sclk),
    .din  (dac_din),
    .busy (tx_busy),
    .done (tx_done)
  );

  assign addr        = addr_q;
  assign dac_cs_n    = cs_n_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = frame_done_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: doc/ecg_dac_seq.md
ECG_DAC_SEQ -- requirements
Module: ecg_dac_seq

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 100000, meaning clk cycles per sample tick (500 Hz at 50 MHz).
REQ-002 SHALL have parameter N_SAMPLES, default 500, meaning waveform table length; addresses 0..N_SAMPLES-1.
REQ-003 SHALL have parameter SCLK_HALF, default 2, meaning clk cycles per DAC SCLK half-period.
REQ-004 SHALL have parameter DAC_CFG, default 4'b0011, meaning 4 config bits prefixed to each DAC frame.
REQ-005 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have en  input  1  level; 1 enables sample ticks and playback.
REQ-008 SHALL have addr  output  9  waveform table address.
REQ-009 SHALL have sample  input  12  table data; valid exactly 1 clk after addr changes (registered table).
REQ-010 SHALL have dac_cs_n, dac_sclk, dac_din  outputs  1 each  serial DAC port.
REQ-011 SHALL have busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have frame_done  output  1  single-cycle pulse per completed frame.
REQ-013 SHALL have overrun_cnt  output  8  count of dropped ticks.

Function
REQ-014 Tick divider SHALL count 0..SAMPLE_DIV-1 while en=1, asserting internal tick for one clk at SAMPLE_DIV-1 then wrapping to 0; held at 0 while en=0.
REQ-015 FSM states SHALL be IDLE, FETCH, LOAD, SHIFT, GAP.
REQ-016 IDLE -> FETCH on tick; FETCH lasts 1 clk (table latency); LOAD lasts 1 clk, captures {DAC_CFG, sample} into 16-bit shift register and drives dac_cs_n=0.
REQ-017 Tick at cycle T SHALL give dac_cs_n=0 at T+2.
REQ-018 SHIFT SHALL send 16 bits MSB first; dac_din changes only while dac_sclk=0; dac_sclk high for SCLK_HALF clk, low for SCLK_HALF clk per bit; SHIFT length 32*SCLK_HALF clk.
REQ-019 After 16th bit's low phase, SHALL enter GAP: dac_cs_n=1, dac_sclk=0 for SCLK_HALF clk, then pulse frame_done, advance addr, return IDLE.
REQ-020 addr SHALL increment by 1 per completed frame and wrap N_SAMPLES-1 -> 0; never exceeds N_SAMPLES-1.
REQ-021 Tick arriving in any state other than IDLE SHALL be dropped and increment overrun_cnt, saturating at 255.
REQ-022 en deasserted mid-frame SHALL let the current frame finish normally; no new frame starts while en=0; addr retained.
REQ-023 Tick and frame completion in same clk: frame completes; tick counted as overrun (FSM not in IDLE that cycle).
REQ-024 dac_sclk and dac_cs_n SHALL be registered outputs, glitch-free.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, addr=0, divider=0, dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0, overrun_cnt=0.
REQ-026 Reset mid-frame SHALL abort frame (dac_cs_n=1 asynchronously); after release, first frame starts at addr 0 on first tick.

Structure
REQ-027 State encoding, DAC frame width (16) and config-bit constants SHALL live in a shared package ecg_pkg.
REQ-028 Serialiser SHALL be one sub-module dac_spi_tx (load, 16-bit word, busy/done), FSM and divider in top.

Verification (SAMPLE_DIV=64, N_SAMPLES=4, SCLK_HALF=2, table sample=addr*0x111)
REQ-029 en=1 after reset -> first tick clk 63, dac_cs_n low at 65, 16 SCLK rising edges, frame bits 0x3000, frame_done once, addr=1.
REQ-030 Run 5 frames -> addr sequence 0,1,2,3,0; frame 4 data 0x3333, frame 5 data 0x3000.
REQ-031 SAMPLE_DIV=40 (frame 68 clk > period) -> every other tick dropped, overrun_cnt increments per drop, saturates at 255 after long run.
REQ-032 en dropped during SHIFT bit 5 -> frame completes all 16 bits, frame_done pulses, then idle with no ticks; re-enable resumes at next addr.
REQ-033 rst pulsed during SHIFT -> dac_cs_n=1 same cycle without clk edge, all outputs reset values, next frame uses addr 0.
REQ-034 Check dac_din stable whenever dac_sclk=1 for all frames (protocol assertion).
